// File: rtl/bullet_launcher_pkg.sv
// Shared game constants and launcher state encoding, also used by the collision FSM.
package bullet_launcher_pkg;

  localparam int unsigned GAME_X_MAX    = 240;
  localparam int unsigned GAME_SCREEN_W = 256;
  localparam int unsigned GAME_SCREEN_H = 128;
  localparam int unsigned GAME_PLAYER_W = 10;

  localparam logic DIR_EAST = 1'b0;
  localparam logic DIR_WEST = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StSpawn,
    StFly,
    StRetire,
    StCooldown
  } launch_state_e;

endpackage

// File: rtl/rising_edge_det.sv
// 1-bit rising-edge detector; the history register clears on reset.
module rising_edge_det (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) d_q <= 1'b0;
    else         d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/bullet_launcher.sv
// Single-bullet launcher: spawns beside the shooter, steps per tick, retires on wall or
// collision, then enforces a tick-counted cooldown before the next shot.
module bullet_launcher
  import bullet_launcher_pkg::*;
#(
  parameter int unsigned X_W        = 8,
  parameter int unsigned Y_W        = 7,
  parameter int unsigned X_MAX      = GAME_X_MAX,
  parameter int unsigned STEP       = 5,
  parameter int unsigned PLAYER_W   = GAME_PLAYER_W,
  parameter int unsigned COOL_TICKS = 8
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           tick,
  input  logic           fire,
  input  logic           fired_by,
  input  logic [X_W-1:0] shooter_x,
  input  logic [Y_W-1:0] shooter_y,
  input  logic           collision,
  output logic [X_W-1:0] bullet_x,
  output logic [Y_W-1:0] bullet_y,
  output logic           bullet_dir,
  output logic           bullet_active,
  output logic           spawn,
  output logic           done,
  output logic           hit,
  output logic           ready
);

  localparam int unsigned CNT_W = (COOL_TICKS > 1) ? $clog2(COOL_TICKS + 1) : 1;
  localparam logic [X_W:0] XMaxW    = (X_W + 1)'(X_MAX);
  localparam logic [X_W:0] StepW    = (X_W + 1)'(STEP);
  localparam logic [X_W:0] PlayerWW = (X_W + 1)'(PLAYER_W);

  launch_state_e  state_q;
  logic [CNT_W-1:0] cnt_q;
  logic           fire_rise;

  logic [X_W:0]   east_spawn;
  logic [X_W-1:0] spawn_x;
  logic [Y_W-1:0] spawn_y;
  logic [X_W:0]   east_next;
  logic           fly_wall;
  logic [X_W-1:0] fly_x;

  rising_edge_det u_fire_edge (
    .clk    (clk),
    .resetn (resetn),
    .d      (fire),
    .rise   (fire_rise)
  );

  // All sums are one bit wider than X so a clamp decision never sees a wrapped value.
  always_comb begin
    east_spawn = {1'b0, shooter_x} + PlayerWW;
    if (fired_by == DIR_EAST) begin
      spawn_x = (east_spawn > XMaxW) ? XMaxW[X_W-1:0] : east_spawn[X_W-1:0];
    end else begin
      spawn_x = (shooter_x == '0) ? '0 : shooter_x - X_W'(1);
    end
    spawn_y = shooter_y + Y_W'(PLAYER_W / 2);

    east_next = {1'b0, bullet_x} + StepW;
    if (bullet_dir == DIR_EAST) begin
      fly_wall = (east_next >= XMaxW);
      fly_x    = fly_wall ? XMaxW[X_W-1:0] : east_next[X_W-1:0];
    end else begin
      fly_wall = ({1'b0, bullet_x} <= StepW);
      fly_x    = fly_wall ? '0 : bullet_x - StepW[X_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      bullet_x      <= '0;
      bullet_y      <= '0;
      bullet_dir    <= 1'b0;
      bullet_active <= 1'b0;
      spawn         <= 1'b0;
      done          <= 1'b0;
      hit           <= 1'b0;
      ready         <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (fire_rise) begin
            state_q       <= StSpawn;
            bullet_dir    <= fired_by;
            bullet_x      <= spawn_x;
            bullet_y      <= spawn_y;
            bullet_active <= 1'b1;
            spawn         <= 1'b1;
            ready         <= 1'b0;
          end
        end
        StSpawn: begin
          spawn   <= 1'b0;
          state_q <= StFly;
        end
        StFly: begin
          if (collision) begin
            state_q       <= StRetire;
            bullet_active <= 1'b0;
            done          <= 1'b1;
            hit           <= 1'b1;
          end else if (tick) begin
            bullet_x <= fly_x;
            if (fly_wall) begin
              state_q       <= StRetire;
              bullet_active <= 1'b0;
              done          <= 1'b1;
              hit           <= 1'b0;
            end
          end
        end
        StRetire: begin
          done  <= 1'b0;
          hit   <= 1'b0;
          cnt_q <= CNT_W'(COOL_TICKS);
          if (COOL_TICKS == 0) begin
            state_q <= StIdle;
            ready   <= 1'b1;
          end else begin
            state_q <= StCooldown;
          end
        end
        StCooldown: begin
          if (tick) begin
            if (cnt_q == CNT_W'(1)) begin
              state_q <= StIdle;
              ready   <= 1'b1;
            end
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_launcher.sv
// Self-checking bench: directed scenarios plus randomized shots against a closed-form model.
module tb_bullet_launcher;

  localparam int XMAX = 240;
  localparam int STEP = 5;
  localparam int PW   = 10;
  localparam int COOL = 8;

  logic       clk = 1'b0;
  logic       resetn, tick, fire, fired_by, collision;
  logic [7:0] shooter_x;
  logic [6:0] shooter_y;
  logic [7:0] bullet_x;
  logic [6:0] bullet_y;
  logic       bullet_dir, bullet_active, spawn, done, hit, ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bullet_launcher #(
    .X_W(8), .Y_W(7), .X_MAX(XMAX), .STEP(STEP), .PLAYER_W(PW), .COOL_TICKS(COOL)
  ) dut (
    .clk(clk), .resetn(resetn), .tick(tick), .fire(fire), .fired_by(fired_by),
    .shooter_x(shooter_x), .shooter_y(shooter_y), .collision(collision),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_dir(bullet_dir),
    .bullet_active(bullet_active), .spawn(spawn), .done(done), .hit(hit), .ready(ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: position after k ticks is closed-form arithmetic, clamped at the wall.
  function automatic int exp_spawn_x(bit dir, int sx);
    if (dir == 1'b0) return (sx + PW > XMAX) ? XMAX : sx + PW;
    return (sx == 0) ? 0 : sx - 1;
  endfunction

  function automatic int exp_spawn_y(int sy);
    return (sy + PW / 2) % 128;
  endfunction

  function automatic bit at_wall(bit dir, int x0, int k);
    if (dir == 1'b0) return (x0 + k * STEP >= XMAX);
    return (x0 - k * STEP <= 0);
  endfunction

  function automatic int pos_after(bit dir, int x0, int k);
    if (at_wall(dir, x0, k)) return (dir == 1'b0) ? XMAX : 0;
    return (dir == 1'b0) ? x0 + k * STEP : x0 - k * STEP;
  endfunction

  task automatic shoot(bit dir, int sx, int sy);
    fired_by  = dir;
    shooter_x = 8'(sx);
    shooter_y = 7'(sy);
    fire      = 1'b1;
    step();
    fire      = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    fire = 1'b0; collision = 1'b1; tick = 1'b1;
    step();
    while (!ready && n < 60) begin
      step();
      n++;
    end
    collision = 1'b0; tick = 1'b0;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL drain_ready: ready=%b required 1 within 60 cycles", ready);
    end
    step();
  endtask

  task automatic test_reset();
    total++;
    if ({bullet_active, spawn, done, hit, ready} !== 5'b00001) begin
      bad++;
      $display("FAIL reset_flags: act/spawn/done/hit/ready=%b required 00001",
               {bullet_active, spawn, done, hit, ready});
    end
    total++;
    if ({bullet_x, bullet_y, bullet_dir} !== 16'h0) begin
      bad++;
      $display("FAIL reset_pos: x=%0d y=%0d dir=%b required 0 0 0", bullet_x, bullet_y,
               bullet_dir);
    end
  endtask

  task automatic test_spawn_east();
    shoot(1'b0, 20, 50);
    total++;
    if ({bullet_active, spawn, done, hit, ready} !== 5'b11000) begin
      bad++;
      $display("FAIL spawn_flags: act/spawn/done/hit/ready=%b required 11000",
               {bullet_active, spawn, done, hit, ready});
    end
    total++;
    if (bullet_x !== 8'd30 || bullet_y !== 7'd55 || bullet_dir !== 1'b0) begin
      bad++;
      $display("FAIL spawn_pos: x=%0d y=%0d dir=%b required 30 55 0", bullet_x, bullet_y,
               bullet_dir);
    end
    step();
    total++;
    if (spawn !== 1'b0 || bullet_active !== 1'b1) begin
      bad++;
      $display("FAIL spawn_pulse: spawn=%b active=%b required 0 1", spawn, bullet_active);
    end
    drain();
  endtask

  task automatic test_east_wall();
    shoot(1'b0, 220, 10);
    total++;
    if (bullet_x !== 8'd230) begin
      bad++;
      $display("FAIL east_spawn_x: x=%0d required 230", bullet_x);
    end
    step();
    tick = 1'b1;
    step();
    total++;
    if (bullet_x !== 8'd235 || done !== 1'b0) begin
      bad++;
      $display("FAIL east_tick1: x=%0d done=%b required 235 0", bullet_x, done);
    end
    step();
    tick = 1'b0;
    total++;
    if (bullet_x !== 8'd240 || {done, hit, bullet_active} !== 3'b100) begin
      bad++;
      $display("FAIL east_wall: x=%0d done/hit/act=%b required 240 100", bullet_x,
               {done, hit, bullet_active});
    end
    step();
    total++;
    if (done !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL east_retire_pulse: done=%b ready=%b required 0 0", done, ready);
    end
    drain();
  endtask

  task automatic test_west_wall();
    shoot(1'b1, 8, 20);
    total++;
    if (bullet_x !== 8'd7 || bullet_dir !== 1'b1) begin
      bad++;
      $display("FAIL west_spawn: x=%0d dir=%b required 7 1", bullet_x, bullet_dir);
    end
    step();
    tick = 1'b1;
    step();
    total++;
    if (bullet_x !== 8'd2 || done !== 1'b0) begin
      bad++;
      $display("FAIL west_tick1: x=%0d done=%b required 2 0", bullet_x, done);
    end
    step();
    tick = 1'b0;
    total++;
    if (bullet_x !== 8'd0 || {done, hit, bullet_active} !== 3'b100) begin
      bad++;
      $display("FAIL west_wall: x=%0d done/hit/act=%b required 0 100", bullet_x,
               {done, hit, bullet_active});
    end
    drain();
  endtask

  task automatic test_collision_tick();
    shoot(1'b0, 100, 30);
    step();
    tick = 1'b1;
    step();
    collision = 1'b1;
    step();
    tick = 1'b0; collision = 1'b0;
    total++;
    if (bullet_x !== 8'd115 || {done, hit, bullet_active} !== 3'b110) begin
      bad++;
      $display("FAIL coll_prio: x=%0d done/hit/act=%b required 115 110", bullet_x,
               {done, hit, bullet_active});
    end
    drain();
  endtask

  task automatic test_cooldown();
    shoot(1'b1, 200, 40);
    step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    step();
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL cool_enter: ready=%b required 0", ready);
    end
    fire = 1'b1; step();
    fire = 1'b0; step();
    total++;
    if (spawn !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL cool_fire_ignored: spawn=%b ready=%b required 0 0", spawn, ready);
    end
    fire = 1'b1;
    for (int t = 1; t <= COOL; t++) begin
      tick = 1'b1; step();
      tick = 1'b0;
      total++;
      if (ready !== (t == COOL) || spawn !== 1'b0) begin
        bad++;
        $display("FAIL cool_tick%0d: ready=%b spawn=%b required %b 0", t, ready, spawn,
                 t == COOL);
      end
      step();
    end
    repeat (3) step();
    total++;
    if (spawn !== 1'b0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL cool_held_fire: spawn=%b ready=%b required 0 1", spawn, ready);
    end
    fire = 1'b0; step();
    fire = 1'b1; step();
    total++;
    if (spawn !== 1'b1) begin
      bad++;
      $display("FAIL cool_repress: spawn=%b required 1", spawn);
    end
    drain();
  endtask

  task automatic test_async_reset();
    shoot(1'b0, 50, 60);
    step();
    tick = 1'b1; step();
    tick = 1'b0;
    total++;
    if (bullet_x !== 8'd65 || bullet_active !== 1'b1) begin
      bad++;
      $display("FAIL areset_pre: x=%0d act=%b required 65 1", bullet_x, bullet_active);
    end
    #2 resetn = 1'b0;
    #1;
    total++;
    if (bullet_active !== 1'b0 || bullet_x !== 8'd0 || ready !== 1'b1) begin
      bad++;
      $display("FAIL areset_now: act=%b x=%0d ready=%b required 0 0 1", bullet_active,
               bullet_x, ready);
    end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      bit dir = 1'($urandom_range(0, 1));
      int sx  = $urandom_range(0, 255);
      int sy  = $urandom_range(0, 127);
      int x0  = exp_spawn_x(dir, sx);
      int ey  = exp_spawn_y(sy);
      int k   = 0;
      int nt  = 0;
      bit retired = 1'b0;
      bit coll;
      shoot(dir, sx, sy);
      total++;
      if (spawn !== 1'b1 || bullet_x !== 8'(x0) || bullet_y !== 7'(ey) || bullet_dir !== dir)
      begin
        bad++;
        $display("FAIL rnd%0d_spawn: spawn=%b x=%0d y=%0d dir=%b required 1 %0d %0d %b", s,
                 spawn, bullet_x, bullet_y, bullet_dir, x0, ey, dir);
      end
      for (int c = 0; c < 300 && !retired; c++) begin
        coll      = ($urandom_range(0, 29) == 0) && (c > 0);
        collision = coll;
        tick      = 1'($urandom_range(0, 1));
        fire      = 1'($urandom_range(0, 1));
        step();
        // First cycle after spawn is the spawn slot; its inputs are ignored.
        if (c == 0) begin
          total++;
          if (bullet_x !== 8'(x0) || bullet_active !== 1'b1) begin
            bad++;
            $display("FAIL rnd%0d_spawn_slot: x=%0d act=%b required %0d 1", s, bullet_x,
                     bullet_active, x0);
          end
        end else if (coll) begin
          retired = 1'b1;
          total++;
          if ({done, hit, bullet_active} !== 3'b110 || bullet_x !== 8'(pos_after(dir, x0, k)))
          begin
            bad++;
            $display("FAIL rnd%0d_coll: d/h/a=%b x=%0d required 110 %0d", s,
                     {done, hit, bullet_active}, bullet_x, pos_after(dir, x0, k));
          end
        end else begin
          if (tick) k++;
          retired = tick && at_wall(dir, x0, k);
          total++;
          if ({done, hit, bullet_active} !== (retired ? 3'b100 : 3'b001) ||
              bullet_x !== 8'(pos_after(dir, x0, k)) || bullet_y !== 7'(ey) || spawn !== 1'b0)
          begin
            bad++;
            $display("FAIL rnd%0d_fly k=%0d: d/h/a=%b x=%0d y=%0d spawn=%b required %b %0d %0d 0",
                     s, k, {done, hit, bullet_active}, bullet_x, bullet_y, spawn,
                     retired ? 3'b100 : 3'b001, pos_after(dir, x0, k), ey);
          end
        end
      end
      collision = 1'b0;
      total++;
      if (!retired) begin
        bad++;
        $display("FAIL rnd%0d_timeout: active=%b required retire within 300 cycles", s,
                 bullet_active);
      end
      tick = 1'($urandom_range(0, 1));
      step();
      total++;
      if (ready !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_retire: ready=%b done=%b required 0 0", s, ready, done);
      end
      for (int c = 0; c < 200; c++) begin
        tick = 1'($urandom_range(0, 1));
        fire = 1'($urandom_range(0, 1));
        step();
        if (tick) nt++;
        total++;
        if (ready !== (nt >= COOL) || spawn !== 1'b0) begin
          bad++;
          $display("FAIL rnd%0d_cool nt=%0d: ready=%b spawn=%b required %b 0", s, nt, ready,
                   spawn, nt >= COOL);
        end
        if (nt >= COOL) break;
      end
      tick = 1'b0; fire = 1'b0;
      step();
    end
  endtask

  initial begin
    resetn = 1'b0; tick = 1'b0; fire = 1'b0; fired_by = 1'b0; collision = 1'b0;
    shooter_x = '0; shooter_y = '0;
    #12;
    test_reset();
    @(negedge clk);
    resetn = 1'b1;
    step();
    test_spawn_east();
    test_east_wall();
    test_west_wall();
    test_collision_tick();
    test_cooldown();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
